// File: rtl/blink.sv
// Clock-divider LED blinker: divides the input clock down to a 50%-duty square
// wave at OUT_FREQ_HZ, toggling a registered output every HALF_PERIOD clocks.
module blink #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OUT_FREQ_HZ = 1,
    localparam int HALF_PERIOD = (OUT_FREQ_HZ > 0) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 1,
    localparam int CNT_W = $clog2(HALF_PERIOD)
) (
    input  logic i_clk_100MHz,
    input  logic i_rst_n,
    output logic o_clk_1Hz
);

    // HALF_PERIOD=1 gives CNT_W=0; keep one counter bit so the logic stays legal.
    localparam int CTR_W = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CTR_W-1:0] LAST = CTR_W'(HALF_PERIOD - 1);

    if (OUT_FREQ_HZ < 1) begin : g_bad_out_freq
        $fatal(1, "blink: OUT_FREQ_HZ must be at least 1");
    end
    if (CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_bad_ratio
        $fatal(1, "blink: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
    end
    if ((OUT_FREQ_HZ >= 1) && (CLK_FREQ_HZ % (2 * OUT_FREQ_HZ) != 0)) begin : g_bad_divisor
        $fatal(1, "blink: CLK_FREQ_HZ must be divisible by 2*OUT_FREQ_HZ");
    end

    logic [CTR_W-1:0] counter;

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counter   <= '0;
            o_clk_1Hz <= 1'b0;
        end else if (counter == LAST) begin
            counter   <= '0;
            o_clk_1Hz <= ~o_clk_1Hz;
        end else begin
            counter   <= counter + CTR_W'(1);
        end
    end

endmodule

// File: tb/tb_blink.sv
// Bench for blink: four instances (HALF_PERIOD 1, 5, 100 and the default)
// share one clock and reset; expected levels come from the released-edge count.
module tb_blink;

    logic clk;
    logic rst_n;
    logic out_hp1, out_hp5, out_hp100, out_def;

    int n_pass  = 0;
    int n_total = 0;
    int edges   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        int         n_clk;
        logic [3:0] exp;    // {def, hp100, hp5, hp1}
    } vec_t;

    vec_t vecs[7];

    blink #(.CLK_FREQ_HZ(2),   .OUT_FREQ_HZ(1)) u_hp1   (.i_clk_100MHz(clk), .i_rst_n(rst_n), .o_clk_1Hz(out_hp1));
    blink #(.CLK_FREQ_HZ(10),  .OUT_FREQ_HZ(1)) u_hp5   (.i_clk_100MHz(clk), .i_rst_n(rst_n), .o_clk_1Hz(out_hp5));
    blink #(.CLK_FREQ_HZ(200), .OUT_FREQ_HZ(1)) u_hp100 (.i_clk_100MHz(clk), .i_rst_n(rst_n), .o_clk_1Hz(out_hp100));
    blink u_def (.i_clk_100MHz(clk), .i_rst_n(rst_n), .o_clk_1Hz(out_def));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_level(input int k, input int hp, input logic rel);
        return rel ? logic'((k / hp) % 2) : 1'b0;
    endfunction

    function automatic logic [3:0] exp_all(input int k, input logic rel);
        return {exp_level(k, 50_000_000, rel), exp_level(k, 100, rel),
                exp_level(k, 5, rel), exp_level(k, 1, rel)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // driver + scoreboard: one clock edge, expected pushed at the edge, popped at negedge
    task automatic tick();
        logic [3:0] want;
        @(posedge clk);
        if (rst_n) edges++;
        else edges = 0;
        exp_q.push_back(exp_all(edges, rst_n));
        @(negedge clk);
        want = exp_q.pop_front();
        check($sformatf("sb_edge%0d", edges), {28'd0, out_def, out_hp100, out_hp5, out_hp1}, {28'd0, want});
    endtask

    initial begin
        int high_cnt;
        int rise_cnt;
        int wait_cnt;
        logic prev;

        vecs[0] = '{1'b0, 20, 4'b0000};
        vecs[1] = '{1'b1, 4,  4'b0000};
        vecs[2] = '{1'b1, 1,  4'b0011};
        vecs[3] = '{1'b1, 5,  4'b0000};
        vecs[4] = '{1'b1, 5,  4'b0011};
        vecs[5] = '{1'b1, 86, 4'b0101};
        vecs[6] = '{1'b1, 99, 4'b0000};

        rst_n = 1'b0;
        #1;
        check("reset_initial", {28'd0, out_def, out_hp100, out_hp5, out_hp1}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            rst_n = vecs[v].rst_n;
            if (!rst_n) edges = 0;
            for (int c = 0; c < vecs[v].n_clk; c++) tick();
            check($sformatf("vec%0d", v), {28'd0, out_def, out_hp100, out_hp5, out_hp1}, {28'd0, vecs[v].exp});
        end

        // HALF_PERIOD=5 duty: 100 clocks = 10 periods, 50 high cycles, 10 rises
        high_cnt = 0;
        rise_cnt = 0;
        prev = out_hp5;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (out_hp5) high_cnt++;
            if (out_hp5 && !prev) rise_cnt++;
            prev = out_hp5;
        end
        check("hp5_high_cycles", high_cnt, 50);
        check("hp5_rises", rise_cnt, 10);

        // mid-period reset: 3 clocks into a high phase of the HALF_PERIOD=5 output
        for (int c = 0; c < 8; c++) tick();
        check("hp5_high_before_reset", {31'd0, out_hp5}, 32'd1);
        check("hp100_high_before_reset", {31'd0, out_hp100}, 32'd1);
        #2;
        rst_n = 1'b0;
        edges = 0;
        #1;
        check("async_reset_clears", {28'd0, out_def, out_hp100, out_hp5, out_hp1}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cnt = 0;
        while (!out_hp5 && wait_cnt <= 20) begin
            tick();
            wait_cnt++;
        end
        check("hp5_rise_after_release", wait_cnt, 5);

        // minimum divide: toggles on every edge
        prev = out_hp1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("hp1_toggle%0d", c), {31'd0, out_hp1}, {31'd0, ~prev});
            prev = out_hp1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
